multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the multicycle RV32I datapath: instruction fetch, register read, ALU, memory access and writeback, one step per cycle, over a single shared ALU and a single shared instruction/data memory.
- Drives every datapath mux select and write enable.
- ImmSrc is decoded combinationally from the opcode.
- Supports lw, sw, R-type, I-type ALU, beq and jal.

Parameters:
- STATE_W, 4, width of state register and of state_dbg.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- op  input  7  opcode field from instruction register; valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access complete; used only with MEM_READY_EN.
- pc_write  output  1  PC register enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
- mem_write  output  1  memory write enable.
- ir_write  output  1  instruction register and old-PC register enable.
- reg_write  output  1  register file write enable.
- result_src  output  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  output  2  ALU A: 00 = PC, 01 = OldPC, 10 = rs1 register.
- alu_src_b  output  2  ALU B: 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- alu_op  output  2  to ALU decoder: 00 = add, 01 = subtract, 10 = funct-decoded.
- imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported.
- state_dbg  output  STATE_W  current state code.

Behaviour:
Reset and clocking
- One clock domain.
- reset_n low asynchronously forces the state to FETCH.
- While reset_n is low, pc_write, ir_write, reg_write, mem_write and illegal_op are forced to 0.
- Other outputs take their FETCH values while in reset.

State codes
- FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10.
- Codes 11-15 are unreachable; if ever entered, go to FETCH with all enables 0.

Output decode (Moore, from state only)
- Any output not listed for a state is 0 in that state.
- alu_op is 00 unless listed.
- FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, result_src 10, pc_update 1.
- DECODE: alu_src_a 01, alu_src_b 01 (computes branch target).
- MEMADR: alu_src_a 10, alu_src_b 01.
- MEMREAD: result_src 00, adr_src 1.
- MEMWB: result_src 01, reg_write 1.
- MEMWRITE: result_src 00, adr_src 1, mem_write 1.
- EXECR: alu_src_a 10, alu_src_b 00, alu_op 10.
- EXECI: alu_src_a 10, alu_src_b 01, alu_op 10.
- ALUWB: result_src 00, reg_write 1.
- BEQ: alu_src_a 10, alu_src_b 00, alu_op 01, result_src 00, branch 1.
- JAL: alu_src_a 01, alu_src_b 10, result_src 00, pc_update 1.
- pc_write = pc_update | (branch & zero). pc_update and branch are internal signals only.
- imm_src is combinational from op, independent of state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.

Transitions
- FETCH -> DECODE.
- DECODE, by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other op -> FETCH, with illegal_op = 1 for that cycle (instruction acts as a NOP).
- MEMADR: op 0000011 -> MEMREAD, otherwise MEMWRITE.
- MEMREAD -> MEMWB.
- MEMWB, MEMWRITE, ALUWB, BEQ -> FETCH.
- EXECR and EXECI -> ALUWB.
- JAL -> ALUWB (writes PC+4 to rd).

Cycle counts
- lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4.
- Unsupported op: 2 cycles.

Other rules
- op is sampled only in DECODE and MEMADR.
- zero matters only in BEQ.
- Reset asserted mid-instruction abandons that instruction. No partial write occurs after the reset edge.

Optional Feature:
- Macro: MEM_READY_EN.
- Defined:
  - FETCH, MEMREAD and MEMWRITE hold their state and hold all outputs until mem_ready = 1.
  - ir_write and pc_write in FETCH assert only in the cycle where mem_ready = 1.
  - mem_write stays asserted for the whole MEMWRITE wait.
  - Each wait cycle adds one cycle to the counts above.
- Undefined:
  - mem_ready is ignored and each of those states lasts exactly one cycle.

Test Plan:
- Release reset_n; op 0000011 (lw) -> state sequence 0,1,2,3,4,0. reg_write = 1 only in cycle 5. result_src = 01 in MEMWB.
- op 0100011 (sw) -> sequence 0,1,2,5,0. mem_write = 1 in one cycle with adr_src = 1. imm_src = 01. reg_write never asserts.
- op 1100011 (beq) -> in BEQ, alu_op = 01 and pc_write follows zero: zero = 1 gives 1, zero = 0 gives 0. Sequence length 3.
- op 1101111 (jal) -> sequence 0,1,10,8,0. pc_write = 1 in FETCH and JAL. imm_src = 11.
- op 1111111 -> sequence 0,1,0. illegal_op pulses exactly once in DECODE. No write enable asserts.
- Assert reset_n low during MEMWRITE -> mem_write drops to 0 immediately (asynchronously) and the state reads 0. With MEM_READY_EN and mem_ready held low for 3 cycles in FETCH -> ir_write stays 0 for those 3 cycles, then asserts for 1 cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional MEM_READY_EN makes FETCH, MEMREAD and MEMWRITE wait for mem_ready.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         imm_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_ok;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_illegal;

`ifdef MEM_READY_EN
    assign w_mem_ok = mem_ready;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = mem_ready;
    assign w_mem_ok           = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        case (r_state)
            FETCH: begin
                w_ir_write  = w_mem_ok;
                w_pc_update = w_mem_ok;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                if (w_mem_ok) w_next = DECODE;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECR;
                    OP_I:         w_next = EXECI;
                    OP_BEQ:       w_next = BEQ;
                    OP_JAL:       w_next = JAL;
                    default: begin
                        w_next    = FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src = 1'b1;
                if (w_mem_ok) w_next = MEMWB;
            end
            MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_next      = FETCH;
            end
            MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                if (w_mem_ok) w_next = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                w_next    = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                w_next    = ALUWB;
            end
            ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                w_branch  = 1'b1;
                w_next    = FETCH;
            end
            JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = ALUWB;
            end
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Enables are gated by reset_n so they drop the instant reset asserts.
    assign pc_write   = reset_n & (w_pc_update | (w_branch & zero));
    assign ir_write   = reset_n & w_ir_write;
    assign reg_write  = reset_n & w_reg_write;
    assign mem_write  = reset_n & w_mem_write;
    assign illegal_op = reset_n & w_illegal;
    assign state_dbg  = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction state-path model
// plus literal tallies (cycles, write-enable counts) for each directed vector.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic [3:0] state_dbg;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int m_path[$];
    int m_idx = 0;
    bit m_active = 1'b0;
    int t_nz, t_regw, t_memw, t_pcw, t_ill;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] dut_vec();
        return {state_dbg, pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal_op};
    endfunction

    function automatic bit supported(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    // Expected outputs for one cycle spent in step s of an instruction.
    function automatic logic [19:0] exp_vec(input int s, input logic [6:0] o, input logic z);
        logic pcw, adr, memw, irw, regw, ill;
        logic [1:0] rs, asa, asb, aop, imm;
        {pcw, adr, memw, irw, regw, ill} = '0;
        {rs, asa, asb, aop} = '0;
        imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 :
              (o == 7'b1101111) ? 2'b11 : 2'b00;
        case (s)
            0:  begin pcw = 1; irw = 1; asb = 2; rs = 2; end
            1:  begin asa = 1; asb = 1; ill = !supported(o); end
            2:  begin asa = 2; asb = 1; end
            3:  begin adr = 1; end
            4:  begin rs = 1; regw = 1; end
            5:  begin adr = 1; memw = 1; end
            6:  begin asa = 2; aop = 2; end
            7:  begin asa = 2; asb = 1; aop = 2; end
            8:  begin regw = 1; end
            9:  begin asa = 2; aop = 1; pcw = z; end
            10: begin asa = 1; asb = 2; pcw = 1; end
            default: ;
        endcase
        return {4'(s), pcw, adr, memw, irw, regw, rs, asa, asb, aop, imm, ill};
    endfunction

    task automatic start_instr(input logic [6:0] o, input logic z);
        op = o;
        zero = z;
        m_path = {};
        case (o)
            7'b0000011: m_path = {0, 1, 2, 3, 4};
            7'b0100011: m_path = {0, 1, 2, 5};
            7'b0110011: m_path = {0, 1, 6, 8};
            7'b0010011: m_path = {0, 1, 7, 8};
            7'b1100011: m_path = {0, 1, 9};
            7'b1101111: m_path = {0, 1, 10, 8};
            default:    m_path = {0, 1};
        endcase
        {t_nz, t_regw, t_memw, t_pcw, t_ill} = '0;
        m_idx = 0;
        m_active = 1'b1;
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns likewise.
    task automatic run_instr(input logic [6:0] o, input logic z, input int cyc,
                             input int regw, input int memw, input int pcw, input int ill);
        string tag;
        tag = $sformatf("op%07b_z%0d", o, z);
        start_instr(o, z);
        for (int c = 0; c < 20 && m_active; c++) begin
            @(negedge clk);
            #1;
        end
        if (m_active) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: model still active", tag);
            m_active = 1'b0;
        end
        chk({tag, " cycles"}, 32'(t_nz + 1), 32'(cyc));
        chk({tag, " reg_write count"}, 32'(t_regw), 32'(regw));
        chk({tag, " mem_write count"}, 32'(t_memw), 32'(memw));
        chk({tag, " pc_write count"}, 32'(t_pcw), 32'(pcw));
        chk({tag, " illegal_op count"}, 32'(t_ill), 32'(ill));
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (m_active) begin
            chk($sformatf("cycle step%0d op%07b", m_path[m_idx], op), 32'(dut_vec()),
                32'(exp_vec(m_path[m_idx], op, zero)));
            t_nz   += (state_dbg != 4'd0) ? 1 : 0;
            t_regw += int'(reg_write);
            t_memw += int'(mem_write);
            t_pcw  += int'(pc_write);
            t_ill  += int'(illegal_op);
            m_idx++;
            if (m_idx >= m_path.size()) m_active = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
`ifdef MEM_READY_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(state_dbg), 32'd0);
        chk("reset enables", {27'd0, pc_write, ir_write, reg_write, mem_write, illegal_op}, 32'd0);
        chk("reset selects", {24'd0, alu_src_b, result_src, alu_src_a, adr_src, 1'b0}, 32'h0000_00a0);

        reset_n = 1'b1;
        run_instr(7'b0000011, 1'b1, 5, 1, 0, 1, 0);
        run_instr(7'b0100011, 1'b0, 4, 0, 1, 1, 0);
        run_instr(7'b0110011, 1'b0, 4, 1, 0, 1, 0);
        run_instr(7'b0010011, 1'b1, 4, 1, 0, 1, 0);
        run_instr(7'b1100011, 1'b1, 3, 0, 0, 2, 0);
        run_instr(7'b1100011, 1'b0, 3, 0, 0, 1, 0);
        run_instr(7'b1101111, 1'b0, 4, 1, 0, 2, 0);
        run_instr(7'b1111111, 1'b0, 2, 0, 0, 1, 1);
        run_instr(7'b0000000, 1'b1, 2, 0, 0, 1, 1);

        // Reset asserted mid-store.
        op = 7'b0100011;
        zero = 1'b0;
        for (int c = 0; c < 10 && state_dbg != 4'd5; c++) begin
            @(negedge clk);
            #1;
        end
        chk("pre-reset memwrite state", 32'(state_dbg), 32'd5);
        chk("pre-reset mem_write", 32'(mem_write), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async reset mem_write", 32'(mem_write), 32'd0);
        chk("async reset state", 32'(state_dbg), 32'd0);
        chk("async reset enables", {27'd0, pc_write, ir_write, reg_write, mem_write, illegal_op}, 32'd0);
        @(posedge clk);
        #1;
        chk("held reset state", 32'(state_dbg), 32'd0);
        chk("held reset ir_write", 32'(ir_write), 32'd0);
        reset_n = 1'b1;
        run_instr(7'b1101111, 1'b1, 4, 1, 0, 2, 0);
        run_instr(7'b0000011, 1'b0, 5, 1, 0, 1, 0);

`ifdef MEM_READY_EN
        mem_ready = 1'b0;
        op = 7'b0110011;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fetch wait ir_write", 32'(ir_write), 32'd0);
            chk("fetch wait state", 32'(state_dbg), 32'd0);
        end
        mem_ready = 1'b1;
        #1;
        chk("fetch ready ir_write", 32'(ir_write), 32'd1);
        chk("fetch ready pc_write", 32'(pc_write), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("after wait state", 32'(state_dbg), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
